// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: sequences the AES engine word, key and result streams for a
// job of N 128-bit blocks, replaying the stored 128-bit key next to every data
// word and pulsing clear/done around the job.
module aes_stream_ctrl #(
  parameter int NB_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [NB_WIDTH-1:0] nblocks_i,
  input  logic                key_we_i,
  input  logic [1:0]          key_idx_i,
  input  logic [31:0]         key_data_i,
  input  logic                src_valid_i,
  output logic                src_ready_o,
  input  logic [31:0]         src_data_i,
  output logic                word_valid_o,
  input  logic                word_ready_i,
  output logic [31:0]         word_data_o,
  output logic                key_valid_o,
  input  logic                key_ready_i,
  output logic [31:0]         key_data_o,
  input  logic                eng_valid_i,
  output logic                eng_ready_o,
  input  logic [31:0]         eng_data_i,
  output logic                sink_valid_o,
  input  logic                sink_ready_i,
  output logic [31:0]         sink_data_o,
  output logic                clr_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CW = NB_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              abort_q, abort_d;
  logic [CW-1:0]     total_q, total_d;
  logic [CW-1:0]     in_cnt_q, in_cnt_d;
  logic [CW-1:0]     key_cnt_q, key_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [3:0][31:0]  key_q, key_d;

  logic              word_xfer, key_xfer, sink_xfer;
  logic              in_more, key_more;
  logic              out_last, in_key_last;

  assign word_xfer = word_valid_o & word_ready_i;
  assign key_xfer  = key_valid_o & key_ready_i;
  assign sink_xfer = sink_valid_o & sink_ready_i;
  assign in_more   = in_cnt_q < total_q;
  assign key_more  = key_cnt_q < total_q;

  // Completion is judged on the post-transfer counts so DONE follows the last
  // sink transfer by exactly one edge.
  assign out_last    = (out_cnt_d == total_q);
  assign in_key_last = (in_cnt_d == total_q) && (key_cnt_d == total_q);

  // State and abort-flag registers; reset drops straight to IDLE without clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic; abort overrides everything and reuses CLEAR with a flag
  // that sends the FSM back to IDLE instead of RUN.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          abort_d = 1'b0;
          state_d = (nblocks_i == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: state_d = abort_q ? S_IDLE : S_RUN;
      S_RUN: begin
        if (out_last)         state_d = S_DONE;
        else if (in_key_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (out_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i && (state_q == S_CLEAR || state_q == S_RUN || state_q == S_DRAIN)) begin
      state_d = S_CLEAR;
      abort_d = 1'b1;
    end
  end

  // Job length, transfer counters and key words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_q   <= '0;
      in_cnt_q  <= '0;
      key_cnt_q <= '0;
      out_cnt_q <= '0;
      key_q     <= '0;
    end else begin
      total_q   <= total_d;
      in_cnt_q  <= in_cnt_d;
      key_cnt_q <= key_cnt_d;
      out_cnt_q <= out_cnt_d;
      key_q     <= key_d;
    end
  end

  // Counters advance on their own stream's transfers; a start in IDLE reloads
  // the job, and key writes only land while idle.
  always_comb begin
    total_d   = total_q;
    key_d     = key_q;
    in_cnt_d  = in_cnt_q + CW'(word_xfer);
    key_cnt_d = key_cnt_q + CW'(key_xfer);
    out_cnt_d = out_cnt_q + CW'(sink_xfer);
    if (state_q == S_IDLE) begin
      if (key_we_i) key_d[key_idx_i] = key_data_i;
      if (start_i) begin
        total_d   = {nblocks_i, 2'b00};
        in_cnt_d  = '0;
        key_cnt_d = '0;
        out_cnt_d = '0;
      end
    end
  end

  // Stream gating and status outputs; data buses are zeroed while gated off.
  always_comb begin
    src_ready_o  = 1'b0;
    word_valid_o = 1'b0;
    word_data_o  = '0;
    key_valid_o  = 1'b0;
    key_data_o   = '0;
    sink_valid_o = 1'b0;
    eng_ready_o  = 1'b0;
    sink_data_o  = '0;
    if (state_q == S_RUN) begin
      word_valid_o = src_valid_i & in_more;
      src_ready_o  = word_ready_i & in_more;
      word_data_o  = src_data_i;
      key_valid_o  = key_more;
      key_data_o   = key_q[key_cnt_q[1:0]];
    end
    if (state_q == S_RUN || state_q == S_DRAIN) begin
      sink_valid_o = eng_valid_i;
      eng_ready_o  = sink_ready_i;
      sink_data_o  = eng_data_i;
    end
    clr_o  = (state_q == S_CLEAR);
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: drives aes_stream_ctrl with a source, a toy engine
// (result = word XOR key) and a sink; expected results are queued when source
// words are accepted and compared when the sink takes a result.
module tb_aes_stream_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, abort_i;
  logic [15:0] nblocks_i;
  logic        key_we_i;
  logic [1:0]  key_idx_i;
  logic [31:0] key_data_i;
  logic        src_valid_i, src_ready_o;
  logic [31:0] src_data_i;
  logic        word_valid_o, word_ready_i;
  logic [31:0] word_data_o;
  logic        key_valid_o, key_ready_i;
  logic [31:0] key_data_o;
  logic        eng_valid_i, eng_ready_o;
  logic [31:0] eng_data_i;
  logic        sink_valid_o, sink_ready_i;
  logic [31:0] sink_data_o;
  logic        clr_o, busy_o, done_o;

  aes_stream_ctrl #(.NB_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .nblocks_i(nblocks_i), .key_we_i(key_we_i), .key_idx_i(key_idx_i),
    .key_data_i(key_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_data_i(src_data_i), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_data_o(word_data_o), .key_valid_o(key_valid_o), .key_ready_i(key_ready_i),
    .key_data_o(key_data_o), .eng_valid_i(eng_valid_i), .eng_ready_o(eng_ready_o),
    .eng_data_i(eng_data_i), .sink_valid_o(sink_valid_o), .sink_ready_i(sink_ready_i),
    .sink_data_o(sink_data_o), .clr_o(clr_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] srcWords [16] = '{
    32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a,
    32'hae2d8a57, 32'h1e03ac9c, 32'h9eb76fac, 32'h45af8e51,
    32'h30c81c46, 32'ha35ce411, 32'he5fbc119, 32'h1a0a52ef,
    32'hf69f2445, 32'hdf4f9b17, 32'had2b417b, 32'he66c3710};
  logic [31:0] keyWords [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
  logic [31:0] keyRef [4];

  logic [31:0] expQ[$];
  logic [31:0] wordQ[$];
  logic [31:0] keyQ[$];
  logic [31:0] resultQ[$];

  int total = 0;
  int bad = 0;
  int srcIdx, srcCount, wordXfers, keyXfers, sinkXfers;
  int clrCount = 0;
  int doneCount = 0;
  bit srcHeld, randMode, sinkBlock;
  bit pendStart, pendAbort, pendKeyWe;
  logic [15:0] pendN;
  logic [1:0]  pendIdx;
  logic [31:0] pendData;
  logic obsClr, obsDone, obsBusy, obsWordValid, obsKeyValid, obsSinkValid;
  logic lastSx, prevSx;

  // Counts one comparison and reports it if observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs at negedge, sample transfers, update models at posedge.
  task automatic runCycle();
    logic wx, kx, sx, srcx;
    logic [31:0] wd, kd, sd;
    @(negedge clk_i);
    start_i    = pendStart;
    abort_i    = pendAbort;
    key_we_i   = pendKeyWe;
    key_idx_i  = pendIdx;
    key_data_i = pendData;
    nblocks_i  = pendN;
    pendStart  = 1'b0;
    pendAbort  = 1'b0;
    pendKeyWe  = 1'b0;
    if (srcIdx < srcCount) begin
      src_valid_i = srcHeld ? 1'b1 : (randMode ? 1'($urandom_range(0, 1)) : 1'b1);
      src_data_i  = srcWords[srcIdx & 15];
    end else begin
      src_valid_i = 1'b0;
      src_data_i  = '0;
    end
    word_ready_i = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
    key_ready_i  = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
    sink_ready_i = sinkBlock ? 1'b0 : (randMode ? 1'($urandom_range(0, 1)) : 1'b1);
    eng_valid_i  = (resultQ.size() > 0);
    eng_data_i   = eng_valid_i ? resultQ[0] : 32'h0;
    #1;
    obsClr = clr_o; obsDone = done_o; obsBusy = busy_o;
    obsWordValid = word_valid_o; obsKeyValid = key_valid_o; obsSinkValid = sink_valid_o;
    wx = word_valid_o & word_ready_i; wd = word_data_o;
    kx = key_valid_o & key_ready_i;   kd = key_data_o;
    sx = sink_valid_o & sink_ready_i; sd = sink_data_o;
    srcx = src_valid_i & src_ready_o;
    srcHeld = src_valid_i & ~srcx;
    prevSx = lastSx;
    lastSx = sx;
    if (obsClr === 1'b1) clrCount++;
    if (obsDone === 1'b1) doneCount++;
    @(posedge clk_i);
    if (wx) begin
      wordQ.push_back(wd);
      expQ.push_back(srcWords[srcIdx & 15] ^ keyRef[wordXfers % 4]);
      wordXfers++;
    end
    if (srcx) srcIdx++;
    if (kx) begin
      checkOutput("keyWord", kd, keyRef[keyXfers % 4]);
      keyQ.push_back(kd);
      keyXfers++;
    end
    if (sx) begin
      if (expQ.size() == 0) checkOutput("sinkUnexpected", sd, 32'hx);
      else checkOutput("sinkData", sd, expQ.pop_front());
      if (resultQ.size() > 0) void'(resultQ.pop_front());
      sinkXfers++;
    end
    while (wordQ.size() > 0 && keyQ.size() > 0)
      resultQ.push_back(wordQ.pop_front() ^ keyQ.pop_front());
  endtask

  task automatic flushModels();
    expQ.delete(); wordQ.delete(); keyQ.delete(); resultQ.delete();
    srcIdx = 0; srcCount = 0; srcHeld = 1'b0;
  endtask

  // Runs a full job of n blocks and checks clear, done and transfer counts.
  task automatic applyStimulus(input int n, input bit rnd);
    int clr0, done0, cyc;
    bit seen;
    randMode = rnd;
    srcIdx = 0; srcHeld = 1'b0; srcCount = 4 * n;
    wordXfers = 0; keyXfers = 0; sinkXfers = 0;
    clr0 = clrCount; done0 = doneCount;
    pendStart = 1'b1; pendN = 16'(n);
    runCycle();
    runCycle();
    checkOutput("clrAfterStart", obsClr, 1);
    checkOutput("busyInClear", obsBusy, 1);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 3000) begin
      if (rnd && cyc == 10) begin
        pendStart = 1'b1; pendN = 16'd3;
        pendKeyWe = 1'b1; pendIdx = 2'd0; pendData = 32'hdeadbeef;
      end
      runCycle();
      cyc++;
      if (obsDone === 1'b1) begin
        seen = 1'b1;
        checkOutput("doneAfterLastSink", prevSx, 1);
      end
    end
    checkOutput("jobFinished", seen, 1);
    runCycle();
    checkOutput("busyAfterDone", obsBusy, 0);
    checkOutput("doneOnePulse", obsDone, 0);
    repeat (3) runCycle();
    checkOutput("doneCount", doneCount - done0, 1);
    checkOutput("clrCount", clrCount - clr0, 1);
    checkOutput("wordXfers", wordXfers, 4 * n);
    checkOutput("keyXfers", keyXfers, 4 * n);
    checkOutput("sinkXfers", sinkXfers, 4 * n);
    checkOutput("leftoverExpected", expQ.size(), 0);
  endtask

  initial begin
    int clr0, done0, cyc;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; nblocks_i = '0;
    key_we_i = 1'b0; key_idx_i = '0; key_data_i = '0;
    src_valid_i = 1'b0; src_data_i = '0; word_ready_i = 1'b0; key_ready_i = 1'b0;
    eng_valid_i = 1'b0; eng_data_i = '0; sink_ready_i = 1'b0;
    pendStart = 1'b0; pendAbort = 1'b0; pendKeyWe = 1'b0; pendN = '0; pendIdx = '0; pendData = '0;
    randMode = 1'b0; sinkBlock = 1'b0; lastSx = 1'b0; prevSx = 1'b0;
    wordXfers = 0; keyXfers = 0; sinkXfers = 0;
    for (int i = 0; i < 4; i++) keyRef[i] = '0;
    flushModels();
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstClr", clr_o, 0);
    checkOutput("rstDone", done_o, 0);
    checkOutput("rstWordValid", word_valid_o, 0);
    checkOutput("rstKeyValid", key_valid_o, 0);
    checkOutput("rstSrcReady", src_ready_o, 0);
    checkOutput("rstSinkValid", sink_valid_o, 0);
    checkOutput("rstEngReady", eng_ready_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("[TB] key load and nominal 4-block job");
    for (int i = 0; i < 4; i++) begin
      pendKeyWe = 1'b1; pendIdx = 2'(i); pendData = keyWords[i];
      runCycle();
      keyRef[i] = keyWords[i];
    end
    applyStimulus(4, 1'b0);

    $display("[TB] random handshakes with start/key writes while busy");
    applyStimulus(4, 1'b1);

    $display("[TB] zero-block job");
    randMode = 1'b0; flushModels();
    wordXfers = 0; keyXfers = 0; sinkXfers = 0;
    clr0 = clrCount; done0 = doneCount;
    pendStart = 1'b1; pendN = 16'd0;
    runCycle();
    runCycle();
    checkOutput("zeroDone", obsDone, 1);
    checkOutput("zeroBusy", obsBusy, 1);
    checkOutput("zeroClr", obsClr, 0);
    runCycle();
    checkOutput("zeroDoneGone", obsDone, 0);
    checkOutput("zeroBusyGone", obsBusy, 0);
    checkOutput("zeroClrCount", clrCount - clr0, 0);
    checkOutput("zeroXfers", wordXfers + keyXfers + sinkXfers, 0);

    $display("[TB] abort after 5 words");
    randMode = 1'b0; flushModels();
    srcCount = 16; wordXfers = 0; keyXfers = 0; sinkXfers = 0;
    clr0 = clrCount; done0 = doneCount;
    pendStart = 1'b1; pendN = 16'd4;
    cyc = 0;
    while (wordXfers < 5 && cyc < 100) begin
      runCycle();
      cyc++;
    end
    checkOutput("abortReached5", wordXfers >= 5, 1);
    pendAbort = 1'b1;
    runCycle();
    runCycle();
    checkOutput("abortClr", obsClr, 1);
    checkOutput("abortWordValid", obsWordValid, 0);
    checkOutput("abortKeyValid", obsKeyValid, 0);
    runCycle();
    checkOutput("abortIdle", obsBusy, 0);
    checkOutput("abortClrOneCycle", obsClr, 0);
    repeat (3) runCycle();
    checkOutput("abortNoDone", doneCount - done0, 0);
    checkOutput("abortClrCount", clrCount - clr0, 2);
    flushModels();
    applyStimulus(1, 1'b0);

    $display("[TB] reset during drain");
    randMode = 1'b0; flushModels(); sinkBlock = 1'b1;
    srcCount = 4; wordXfers = 0; keyXfers = 0; sinkXfers = 0;
    pendStart = 1'b1; pendN = 16'd1;
    cyc = 0;
    while (!(wordXfers == 4 && keyXfers == 4) && cyc < 100) begin
      runCycle();
      cyc++;
    end
    runCycle();
    checkOutput("drainBusy", obsBusy, 1);
    checkOutput("drainSinkValid", obsSinkValid, 1);
    checkOutput("drainKeyValid", obsKeyValid, 0);
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("asyncRstBusy", busy_o, 0);
    checkOutput("asyncRstSinkValid", sink_valid_o, 0);
    checkOutput("asyncRstEngReady", eng_ready_o, 0);
    checkOutput("asyncRstClr", clr_o, 0);
    checkOutput("asyncRstDone", done_o, 0);
    flushModels();
    for (int i = 0; i < 4; i++) keyRef[i] = '0;
    sinkBlock = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
